dice_rules_engine: RTL

DICE_RULES_ENGINE -- requirements
Module: dice_rules_engine

---
 rtl/dice_rules_engine.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dice_rules_engine.sv
// ----------------------------------------------------------------------------
// dice_rules_engine
//
// Purpose: evaluates a settled pair of dice against the drinking-game rule
// table, emits a one-cycle event with a sip count, tracks whose turn it is
// and who currently holds the Dreimann role, then holds the result for a
// fixed number of timebase ticks (with a blink enable) before accepting the
// next roll.
//
// Ports:
//   clk          in   system clock, all state on the rising edge
//   rst_n        in   synchronous active-low reset
//   die1, die2   in   settled die values (legal 1..6), sampled on an accepted roll
//   roll_done    in   one-cycle strobe: dice settled and valid this cycle
//   tick         in   one-cycle timebase strobe
//   event_code   out  rule result of last roll (0 NONE,1 DM,2 LEFT,3 RIGHT,
//                     4 PASCH,6 DM_DOUBLE,7 ERR)
//   event_valid  out  one-cycle strobe: event_code/sips/turn/dm_* just updated
//   sips         out  sip count attached to the event
//   turn         out  index of the player on turn
//   dm_player    out  index of the current Dreimann
//   dm_valid     out  a Dreimann exists
//   flash        out  blink enable while the result is held
//   busy         out  high while a roll is being evaluated or held
//   dbg_state    out  current FSM state (0 IDLE, 1 EVAL, 2 HOLD)
//
// Handshake: roll_done is a fire-and-forget strobe with no ready back-pressure;
// it is accepted only while idle (busy low) and dropped otherwise. event_valid
// is a single-cycle strobe with no ready; the consumer must take it that cycle.
// ----------------------------------------------------------------------------
module dice_rules_engine #(
    parameter int NUM_PLAYERS = 4,
    parameter int HOLD_TICKS  = 500,
    parameter int FLASH_DIV   = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] die1,
    input  logic [2:0] die2,
    input  logic       roll_done,
    input  logic       tick,
    output logic [2:0] event_code,
    output logic       event_valid,
    output logic [3:0] sips,
    output logic [1:0] turn,
    output logic [1:0] dm_player,
    output logic       dm_valid,
    output logic       flash,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam int HCW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int FCW = (FLASH_DIV  > 1) ? $clog2(FLASH_DIV)  : 1;

    localparam logic [2:0] EV_NONE      = 3'd0;
    localparam logic [2:0] EV_DM        = 3'd1;
    localparam logic [2:0] EV_LEFT      = 3'd2;
    localparam logic [2:0] EV_RIGHT     = 3'd3;
    localparam logic [2:0] EV_PASCH     = 3'd4;
    localparam logic [2:0] EV_DM_DOUBLE = 3'd6;
    localparam logic [2:0] EV_ERR       = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_die1;
    logic [2:0]       r_die2;
    logic [HCW-1:0]   r_hold_cnt;
    logic [FCW-1:0]   r_flash_cnt;

    logic [3:0]       w_sum;
    logic [2:0]       w_code;
    logic [3:0]       w_sips;
    logic [1:0]       w_turn_next;

    assign dbg_state = r_state;

    // Four bits wide so 6+6 (or 7+7 on illegal input) cannot wrap.
    assign w_sum = {1'b0, r_die1} + {1'b0, r_die2};

    assign w_turn_next = (turn == 2'(NUM_PLAYERS - 1)) ? 2'd0 : turn + 2'd1;

    // Rule decode on the captured dice; order of the if-chain is the priority.
    always_comb begin
        w_code = EV_NONE;
        w_sips = 4'd0;
        if (r_die1 == 3'd0 || r_die1 == 3'd7 || r_die2 == 3'd0 || r_die2 == 3'd7) begin
            w_code = EV_ERR;
            w_sips = 4'd0;
        end else if (r_die1 == 3'd3 && r_die2 == 3'd3) begin
            w_code = EV_DM_DOUBLE;
            w_sips = 4'd2;
        end else if (r_die1 == 3'd3 || r_die2 == 3'd3) begin
            w_code = EV_DM;
            w_sips = 4'd1;
        end else if (w_sum == 4'd7) begin
            w_code = EV_LEFT;
            w_sips = 4'd1;
        end else if (w_sum == 4'd11) begin
            w_code = EV_RIGHT;
            w_sips = 4'd1;
        end else if (r_die1 == r_die2) begin
            w_code = EV_PASCH;
            w_sips = {1'b0, r_die1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_die1      <= 3'd0;
            r_die2      <= 3'd0;
            r_hold_cnt  <= '0;
            r_flash_cnt <= '0;
            event_code  <= EV_NONE;
            event_valid <= 1'b0;
            sips        <= 4'd0;
            turn        <= 2'd0;
            dm_player   <= 2'd0;
            dm_valid    <= 1'b0;
            flash       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            event_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    flash <= 1'b0;
                    if (roll_done) begin
                        r_die1  <= die1;
                        r_die2  <= die2;
                        r_state <= S_EVAL;
                        busy    <= 1'b1;
                    end
                end
                S_EVAL: begin
                    event_code  <= w_code;
                    sips        <= w_sips;
                    event_valid <= 1'b1;
                    if (w_code == EV_DM || w_code == EV_DM_DOUBLE) begin
                        dm_player <= turn;
                        dm_valid  <= 1'b1;
                    end
                    if (w_code == EV_NONE) begin
                        turn <= w_turn_next;
                    end
                    r_hold_cnt  <= '0;
                    r_flash_cnt <= '0;
                    flash       <= 1'b0;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (tick) begin
                        if (r_flash_cnt == FCW'(FLASH_DIV - 1)) begin
                            r_flash_cnt <= '0;
                            flash       <= ~flash;
                        end else begin
                            r_flash_cnt <= r_flash_cnt + FCW'(1);
                        end
                        if (r_hold_cnt == HCW'(HOLD_TICKS - 1)) begin
                            // Leaving HOLD: blanking wins over the toggle above.
                            r_hold_cnt <= '0;
                            flash      <= 1'b0;
                            busy       <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + HCW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    flash   <= 1'b0;
                end
            endcase
        end
    end

endmodule
